// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: one registered-product multiply and a 32-step
// radix-2 restoring divider behind an IDLE/MUL/DIV/DONE controller.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [4:0]       ALU_Ctrl_op,
  input  logic [XLEN-1:0]  Rs1_Data,
  input  logic [XLEN-1:0]  Rs2_Data,
  input  logic [TAG_W-1:0] In_Rd,
  output logic             Out_Valid,
  output logic [XLEN-1:0]  Result,
  output logic [TAG_W-1:0] Out_Rd
);

  localparam logic [4:0] ALU_CTRL_MUL    = 5'h10;
  localparam logic [4:0] ALU_CTRL_MULH   = 5'h11;
  localparam logic [4:0] ALU_CTRL_MULHSU = 5'h12;
  localparam logic [4:0] ALU_CTRL_MULHU  = 5'h13;
  localparam logic [4:0] ALU_CTRL_DIV    = 5'h14;
  localparam logic [4:0] ALU_CTRL_DIVU   = 5'h15;
  localparam logic [4:0] ALU_CTRL_REM    = 5'h16;
  localparam logic [4:0] ALU_CTRL_REMU   = 5'h17;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e           state_q;
  logic [4:0]       op_q;
  logic [TAG_W-1:0] rd_q;
  logic [XLEN-1:0]  a_q;      // multiplicand, or dividend magnitude shifting into quotient
  logic [XLEN-1:0]  b_q;      // multiplier, or divisor magnitude
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  res_q;
  logic [5:0]       cnt_q;
  logic             neg_q;
  logic             dvd_neg_q;

  logic              is_m, accept, in_div, in_sdiv, in_rem, dvs_zero, ovf;
  logic [XLEN-1:0]   special_res, rs1_mag, rs2_mag;
  logic              a_sx, b_sx;
  logic [2*XLEN-1:0] a_ext, b_ext, product;
  logic [XLEN-1:0]   mul_res, div_res;
  logic [XLEN:0]     trial;
  logic              op_rem_q;

  assign In_Ready = (state_q == S_IDLE);

  always_comb begin
    is_m     = (ALU_Ctrl_op >= ALU_CTRL_MUL) && (ALU_Ctrl_op <= ALU_CTRL_REMU);
    accept   = In_Valid && In_Ready && is_m;
    in_div   = (ALU_Ctrl_op == ALU_CTRL_DIV) || (ALU_Ctrl_op == ALU_CTRL_DIVU) ||
               (ALU_Ctrl_op == ALU_CTRL_REM) || (ALU_Ctrl_op == ALU_CTRL_REMU);
    in_sdiv  = (ALU_Ctrl_op == ALU_CTRL_DIV) || (ALU_Ctrl_op == ALU_CTRL_REM);
    in_rem   = (ALU_Ctrl_op == ALU_CTRL_REM) || (ALU_Ctrl_op == ALU_CTRL_REMU);
    dvs_zero = (Rs2_Data == '0);
    ovf      = in_sdiv && (Rs1_Data == INT_MIN) && (Rs2_Data == '1);
    if (dvs_zero) special_res = in_rem ? Rs1_Data : '1;
    else          special_res = in_rem ? '0 : INT_MIN;
    rs1_mag  = (in_sdiv && Rs1_Data[XLEN-1]) ? -Rs1_Data : Rs1_Data;
    rs2_mag  = (in_sdiv && Rs2_Data[XLEN-1]) ? -Rs2_Data : Rs2_Data;

    // Low 2*XLEN bits of the 33x33 signed product equal those of the extended product.
    a_sx    = (op_q != ALU_CTRL_MULHU) && a_q[XLEN-1];
    b_sx    = ((op_q == ALU_CTRL_MUL) || (op_q == ALU_CTRL_MULH)) && b_q[XLEN-1];
    a_ext   = {{XLEN{a_sx}}, a_q};
    b_ext   = {{XLEN{b_sx}}, b_q};
    product = a_ext * b_ext;
    mul_res = (op_q == ALU_CTRL_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    trial    = {rem_q, a_q[XLEN-1]} - {1'b0, b_q};
    op_rem_q = (op_q == ALU_CTRL_REM) || (op_q == ALU_CTRL_REMU);
    if (op_rem_q) div_res = dvd_neg_q ? -rem_q : rem_q;
    else          div_res = neg_q ? -a_q : a_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      Out_Valid <= 1'b0;
      Result    <= '0;
      Out_Rd    <= '0;
    end else begin
      // The result strobe follows DONE by one edge, so a Flush seen in DONE cannot cancel it.
      Out_Valid <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        Result <= res_q;
        Out_Rd <= rd_q;
      end
      if (Flush) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              op_q  <= ALU_Ctrl_op;
              rd_q  <= In_Rd;
              rem_q <= '0;
              cnt_q <= '0;
              if (!in_div) begin
                a_q     <= Rs1_Data;
                b_q     <= Rs2_Data;
                state_q <= S_MUL;
              end else if (dvs_zero || ovf) begin
                res_q   <= special_res;
                state_q <= S_DONE;
              end else begin
                a_q       <= rs1_mag;
                b_q       <= rs2_mag;
                neg_q     <= in_sdiv && (Rs1_Data[XLEN-1] ^ Rs2_Data[XLEN-1]);
                dvd_neg_q <= in_sdiv && Rs1_Data[XLEN-1];
                state_q   <= S_DIV;
              end
            end
          end
          S_MUL: begin
            res_q   <= mul_res;
            state_q <= S_DONE;
          end
          S_DIV: begin
            if (!cnt_q[5]) begin
              if (!trial[XLEN]) rem_q <= trial[XLEN-1:0];
              else              rem_q <= {rem_q[XLEN-2:0], a_q[XLEN-1]};
              a_q   <= {a_q[XLEN-2:0], ~trial[XLEN]};
              cnt_q <= cnt_q + 6'd1;
            end else begin
              res_q   <= div_res;
              state_q <= S_DONE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
